// File: rtl/uart_dbg_bridge.sv
// UART-to-debug-port bridge: 9-byte 8N1 request frames in, 5-byte status/result frames out.
// Optional ready-wait timeout is enabled by defining DBG_BRIDGE_TIMEOUT_EN.
module uart_dbg_bridge #(
  parameter int unsigned CLKS_PER_BIT   = 868,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic        uart_rx_i,
  output logic        uart_tx_o,
  output logic [7:0]  dbg_cmd_o,
  output logic [31:0] dbg_addr_o,
  output logic [31:0] dbg_data_o,
  input  logic [31:0] dbg_data_i,
  input  logic        dbg_ready_i,
  output logic        busy_o
);

  localparam logic [15:0] BitLast  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HalfLast = 16'(CLKS_PER_BIT / 2 - 1);

  if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535) begin : g_bad_clks_per_bit
    $error("uart_dbg_bridge: CLKS_PER_BIT must be in 4..65535");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("uart_dbg_bridge: TIMEOUT_CYCLES must be at least 1");
  end

  // ---------------------------------------------------------------- RX engine
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  rx_state_e   rx_state_q, rx_state_d;
  logic        rx_meta_q, rx_sync_q, rx_prev_q;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        rx_valid, rx_err;

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_meta_q  <= uart_rx_i;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 16'd1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_valid   = 1'b0;
    rx_err     = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) rx_state_d = RxStart;
      end
      RxStart: begin
        // Line back high at mid start bit means a glitch, not a start.
        if (rx_cnt_q == HalfLast) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? RxIdle : RxData;
        end
      end
      RxData: begin
        if (rx_cnt_q == BitLast) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RxStop;
        end
      end
      RxStop: begin
        if (rx_cnt_q == BitLast) begin
          rx_valid   = rx_sync_q;
          rx_err     = !rx_sync_q;
          rx_state_d = RxIdle;
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  // ------------------------------------------------------------ frame parser
  typedef enum logic [2:0] {StCmd, StAddr, StData, StReq, StResp} state_e;

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [31:0] addr_q, addr_d, data_q, data_d;
  logic [7:0]  dbg_cmd_q, dbg_cmd_d;
  logic [31:0] dbg_addr_q, dbg_addr_d, dbg_data_q, dbg_data_d;
  logic        busy_q, busy_d;
  logic [39:0] tx_frame_q, tx_frame_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]  tx_bit_q, tx_bit_d;
  logic [2:0]  tx_byte_q, tx_byte_d;
  logic        tx_active_q, tx_active_d;
  logic        tx_q, tx_d;
  logic        req_timeout, tx_last;

`ifdef DBG_BRIDGE_TIMEOUT_EN
  localparam logic [31:0] ToLast = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] to_cnt_q, to_cnt_d;

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) to_cnt_q <= '0;
    else       to_cnt_q <= to_cnt_d;
  end

  always_comb begin
    to_cnt_d = '0;
    if (state_q == StReq && !dbg_ready_i) to_cnt_d = to_cnt_q + 32'd1;
  end

  assign req_timeout = (state_q == StReq) && !dbg_ready_i && (to_cnt_q == ToLast);
`else
  assign req_timeout = 1'b0;
`endif

  assign tx_last = (state_q == StResp) && tx_active_q && (tx_cnt_q == BitLast) &&
                   (tx_bit_q == 4'd9) && (tx_byte_q == 3'd4);

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) state_q <= StCmd;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StCmd:  if (rx_valid && rx_shift_q != 8'h00) state_d = StAddr;
      StAddr: begin
        if (rx_err)                          state_d = StCmd;
        else if (rx_valid && idx_q == 2'd3)  state_d = StData;
      end
      StData: begin
        if (rx_err)                          state_d = StCmd;
        else if (rx_valid && idx_q == 2'd3)  state_d = StReq;
      end
      StReq:  if (dbg_ready_i || req_timeout) state_d = StResp;
      StResp: if (tx_last) state_d = StCmd;
      default: state_d = StCmd;
    endcase
  end

  always_comb begin
    idx_d       = idx_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    data_d      = data_q;
    dbg_cmd_d   = dbg_cmd_q;
    dbg_addr_d  = dbg_addr_q;
    dbg_data_d  = dbg_data_q;
    busy_d      = busy_q;
    tx_frame_d  = tx_frame_q;
    tx_cnt_d    = tx_cnt_q;
    tx_bit_d    = tx_bit_q;
    tx_byte_d   = tx_byte_q;
    tx_active_d = tx_active_q;
    tx_d        = tx_q;
    unique case (state_q)
      StCmd: begin
        if (rx_valid && rx_shift_q != 8'h00) begin
          cmd_d  = rx_shift_q;
          idx_d  = '0;
          busy_d = 1'b1;
        end
      end
      StAddr: begin
        if (rx_err) begin
          busy_d = 1'b0;
        end else if (rx_valid) begin
          addr_d = {rx_shift_q, addr_q[31:8]};
          idx_d  = idx_q + 2'd1;
        end
      end
      StData: begin
        if (rx_err) begin
          busy_d = 1'b0;
        end else if (rx_valid) begin
          data_d = {rx_shift_q, data_q[31:8]};
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            dbg_cmd_d  = cmd_q;
            dbg_addr_d = addr_q;
            dbg_data_d = {rx_shift_q, data_q[31:8]};
          end
        end
      end
      StReq: begin
        // Ready wins over a same-cycle timeout.
        if (dbg_ready_i) begin
          dbg_cmd_d  = 8'h00;
          tx_frame_d = {dbg_data_i, 8'h00};
        end else if (req_timeout) begin
          dbg_cmd_d  = 8'h00;
          tx_frame_d = {32'h0, 8'h01};
        end
      end
      StResp: begin
        // Bit 0 is start, 1..8 data LSB-first (shifted out of tx_frame), 9 is stop.
        if (!tx_active_q) begin
          tx_active_d = 1'b1;
          tx_d        = 1'b0;
          tx_cnt_d    = '0;
          tx_bit_d    = '0;
          tx_byte_d   = '0;
        end else if (tx_cnt_q != BitLast) begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end else begin
          tx_cnt_d = '0;
          if (tx_bit_q == 4'd9) begin
            if (tx_byte_q == 3'd4) begin
              tx_active_d = 1'b0;
              tx_d        = 1'b1;
              busy_d      = 1'b0;
            end else begin
              tx_byte_d = tx_byte_q + 3'd1;
              tx_bit_d  = '0;
              tx_d      = 1'b0;
            end
          end else begin
            tx_bit_d = tx_bit_q + 4'd1;
            if (tx_bit_q == 4'd8) begin
              tx_d = 1'b1;
            end else begin
              tx_d       = tx_frame_q[0];
              tx_frame_d = tx_frame_q >> 1;
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      idx_q       <= '0;
      cmd_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      dbg_cmd_q   <= '0;
      dbg_addr_q  <= '0;
      dbg_data_q  <= '0;
      busy_q      <= 1'b0;
      tx_frame_q  <= '0;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_byte_q   <= '0;
      tx_active_q <= 1'b0;
      tx_q        <= 1'b1;
    end else begin
      idx_q       <= idx_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      dbg_cmd_q   <= dbg_cmd_d;
      dbg_addr_q  <= dbg_addr_d;
      dbg_data_q  <= dbg_data_d;
      busy_q      <= busy_d;
      tx_frame_q  <= tx_frame_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_byte_q   <= tx_byte_d;
      tx_active_q <= tx_active_d;
      tx_q        <= tx_d;
    end
  end

  assign uart_tx_o  = tx_q;
  assign dbg_cmd_o  = dbg_cmd_q;
  assign dbg_addr_o = dbg_addr_q;
  assign dbg_data_o = dbg_data_q;
  assign busy_o     = busy_q;

endmodule

// File: doc/uart_dbg_bridge.md
Name: uart_dbg_bridge

Overview:
- Host-side front end for the debug port of the core subsystem. Sits directly upstream of the debug command inputs (cmd/addr/data/ready) of the core top level.
- Receives framed debug commands over an 8N1 UART and drives them onto the debug command interface. Waits for completion, then returns a status byte and the 32-bit result word over UART TX.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); legal range 4..65535.
- TIMEOUT_CYCLES, 65536, ready-wait limit; used only when DBG_BRIDGE_TIMEOUT_EN is defined.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst_i  input  1  asynchronous reset, active-high.
- uart_rx_i  input  1  serial in, idle high, asynchronous to clk.
- uart_tx_o  output  1  serial out, idle high.
- dbg_cmd_o  output  8  debug command; 0x00 = NOP/no request.
- dbg_addr_o  output  32  debug address.
- dbg_data_o  output  32  debug write data.
- dbg_data_i  input  32  debug read data, valid while dbg_ready_i=1.
- dbg_ready_i  input  1  debug module done/accept strobe.
- busy_o  output  1  high from first frame byte until last response stop bit sent.

Behaviour:
- Reset (async on rst_i=1): uart_tx_o=1, dbg_cmd_o=0x00, dbg_addr_o=0, dbg_data_o=0, busy_o=0; FSM in S_CMD; RX/TX bit counters cleared. A reset mid-frame or mid-transmission aborts it immediately; TX line returns high.
- RX path: 2-FF synchronizer on uart_rx_i.
  - Start is a falling edge in idle. Re-check low at CLKS_PER_BIT/2; if high, treat as a glitch and return to idle.
  - Sample 8 data bits LSB-first at bit centres, then the stop bit.
  - Stop=0 is a framing error: byte discarded, parser forced to S_CMD.
  - rx_valid pulses for 1 cycle at the stop-bit sample.
- Request frame: 9 bytes = CMD, ADDR[7:0]..ADDR[31:24], DATA[7:0]..DATA[31:24] (little-endian).
- FSM:
  - S_CMD: on rx_valid, if byte=0x00, ignore it (no response, stay). Otherwise latch cmd, set busy_o=1, go to S_ADDR, byte index=0.
  - S_ADDR: 4 bytes shifted into the addr shadow; go to S_DATA after the 4th.
  - S_DATA: 4 bytes into the data shadow; after the 4th, go to S_REQ next cycle.
  - S_REQ: dbg_cmd_o/dbg_addr_o/dbg_data_o driven from the shadows and held stable. The first cycle with dbg_ready_i=1 (including the very first S_REQ cycle) is acceptance:
    - capture dbg_data_i into the response register;
    - status=0x00;
    - dbg_cmd_o=0x00 from the next cycle (addr/data keep their values);
    - go to S_RESP.
  - S_RESP: transmit 5 bytes: STATUS, RESP[7:0]..RESP[31:24], each 8N1 LSB-first, back-to-back with no idle bits. The first start bit begins the cycle after entering S_RESP. After the last stop bit (CLKS_PER_BIT cycles), busy_o=0 and go to S_CMD.
- Bytes received while in S_REQ or S_RESP are dropped. The RX engine keeps running so it stays bit-aligned.
- dbg_ready_i outside S_REQ is ignored.
- Each TX bit lasts exactly CLKS_PER_BIT cycles; a full response is 50*CLKS_PER_BIT cycles.
- No inter-byte timeout on RX; a partial frame persists until completed, a framing error occurs, or reset.

Optional Feature:
- DBG_BRIDGE_TIMEOUT_EN defined: a counter runs in S_REQ.
  - If TIMEOUT_CYCLES cycles elapse with no dbg_ready_i, dbg_cmd_o drops to 0x00 next cycle.
  - Response is STATUS=0x01 with data bytes 0x00; go to S_RESP.
  - dbg_ready_i on the same cycle the count expires wins (status 0x00).
- Not defined: S_REQ waits indefinitely; status byte is always 0x00.

Test Plan:
- Common setup: CLKS_PER_BIT=4.
- Reset values: hold rst_i=1 mid-RX-frame, release -> uart_tx_o=1, dbg_cmd_o=0, busy_o=0. Fresh frame 0x02,78 56 34 12,EF BE AD DE -> dbg_addr_o=0x12345678, dbg_data_o=0xDEADBEEF, dbg_cmd_o=0x02.
- Read round-trip: frame cmd 0x01, addr 0x00000010. dbg_ready_i pulsed 5 cycles after cmd asserts, with dbg_data_i=0xCAFEF00D -> dbg_cmd_o=0 next cycle; TX bytes 00,0D,F0,FE,CA; busy_o falls 200 cycles after the first start bit.
- Immediate ready: dbg_ready_i tied high -> acceptance in the first S_REQ cycle; dbg_cmd_o high exactly 1 cycle.
- Framing error: send CMD 0x03, 2 addr bytes, then a byte with stop=0, then a full valid frame -> only the second frame is issued; no response for the first.
- NOP and overrun: byte 0x00 alone -> no dbg_cmd_o activity, busy_o stays 0. During S_RESP, inject 3 bytes -> ignored; the next full frame is processed normally.
- Timeout (with DBG_BRIDGE_TIMEOUT_EN, TIMEOUT_CYCLES=16): never assert ready -> dbg_cmd_o clears after 16 cycles; TX 01,00,00,00,00.
